// File: rtl/pooling_max_ctrl.sv
// pooling_max_ctrl: steers a raster pixel stream into a bank of max cells and drains one pooled row per band.
// Optional build macro POOL_OUT_REG_EN adds a one-entry registered output stage after the drain mux.
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module pooling_max_ctrl #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int POOL_SIZE  = 2,
  parameter int NUM_CELLS  = IMG_WIDTH / POOL_SIZE
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              in_valid,
  input  logic [`DATA_WIDTH-1:0]            in_data,
  output logic                              in_ready,
  output logic [NUM_CELLS*`DATA_WIDTH-1:0]  cell_a,
  output logic [NUM_CELLS-1:0]              cell_clear,
  input  logic [NUM_CELLS*`DATA_WIDTH-1:0]  cell_result,
  output logic                              out_valid,
  output logic [`DATA_WIDTH-1:0]            out_data,
  input  logic                              out_ready,
  output logic                              busy,
  output logic                              done
);

  localparam int DW = `DATA_WIDTH;
  localparam int CW = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  localparam int PW = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam int RW = $clog2(IMG_HEIGHT + 1);

  localparam logic [CW-1:0] LAST_CELL = CW'(NUM_CELLS - 1);
  localparam logic [PW-1:0] LAST_PH   = PW'(POOL_SIZE - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(IMG_HEIGHT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_FILL  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4,
    S_FLUSH = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cell_q, cell_d;     // column window = owning cell
  logic [PW-1:0] ph_q, ph_d;         // column offset inside the window
  logic [PW-1:0] rph_q, rph_d;       // row offset inside the band
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] didx_q, didx_d;
  logic [DW-1:0] drain_val;
  logic          drain_take;

  assign drain_val = cell_result[didx_q*DW +: DW];

`ifdef POOL_OUT_REG_EN
  logic          ovalid_q;
  logic [DW-1:0] odata_q;

  assign drain_take = (state_q == S_DRAIN) && (!ovalid_q || out_ready);
  assign out_valid  = ovalid_q;
  assign out_data   = odata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovalid_q <= 1'b0;
      odata_q  <= '0;
    end else if (drain_take) begin
      ovalid_q <= 1'b1;
      odata_q  <= drain_val;
    end else if (out_ready) begin
      ovalid_q <= 1'b0;
    end
  end
`else
  assign drain_take = (state_q == S_DRAIN) && out_ready;
  assign out_valid  = (state_q == S_DRAIN);
  assign out_data   = (state_q == S_DRAIN) ? drain_val : '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cell_q  <= '0;
      ph_q    <= '0;
      rph_q   <= '0;
      row_q   <= '0;
      didx_q  <= '0;
    end else begin
      state_q <= state_d;
      cell_q  <= cell_d;
      ph_q    <= ph_d;
      rph_q   <= rph_d;
      row_q   <= row_d;
      didx_q  <= didx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cell_d     = cell_q;
    ph_d       = ph_q;
    rph_d      = rph_q;
    row_d      = row_q;
    didx_d     = didx_q;
    in_ready   = 1'b0;
    cell_a     = '0;
    cell_clear = '0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT;
      end

      S_INIT: begin
        busy       = 1'b1;
        cell_clear = '1;
        cell_d     = '0;
        ph_d       = '0;
        rph_d      = '0;
        row_d      = '0;
        didx_d     = '0;
        state_d    = S_FILL;
      end

      S_FILL: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) begin
          cell_a[cell_q*DW +: DW] = in_data;
          if (ph_q == LAST_PH) begin
            ph_d = '0;
            if (cell_q == LAST_CELL) begin
              cell_d = '0;
              row_d  = row_q + 1'b1;
              if (rph_q == LAST_PH) begin
                rph_d   = '0;
                didx_d  = '0;
                state_d = S_DRAIN;
              end else begin
                rph_d = rph_q + 1'b1;
              end
            end else begin
              cell_d = cell_q + 1'b1;
            end
          end else begin
            ph_d = ph_q + 1'b1;
          end
        end
      end

      S_DRAIN: begin
        busy = 1'b1;
        // A cell is cleared the cycle its value leaves the drain mux.
        if (drain_take) begin
          cell_clear[didx_q] = 1'b1;
          if (didx_q == LAST_CELL) begin
            didx_d = '0;
`ifdef POOL_OUT_REG_EN
            state_d = (row_q == LAST_ROW) ? S_FLUSH : S_FILL;
`else
            state_d = (row_q == LAST_ROW) ? S_DONE : S_FILL;
`endif
          end else begin
            didx_d = didx_q + 1'b1;
          end
        end
      end

`ifdef POOL_OUT_REG_EN
      S_FLUSH: begin
        busy = 1'b1;
        if (!ovalid_q || out_ready) state_d = S_DONE;
      end
`endif

      S_DONE: begin
        done    = 1'b1;
        cell_d  = '0;
        ph_d    = '0;
        rph_d   = '0;
        row_d   = '0;
        didx_d  = '0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/pooling_max_ctrl.md
Name: pooling_max_ctrl

Overview:
Sequencer for a bank of pooling_max_cell instances performing non-overlapping POOL_SIZE x POOL_SIZE max pooling on a raster-order pixel stream.
- Accepts pixels with a valid/ready handshake and steers each pixel to the cell that owns its column window.
- Neutralises idle cells and clears cells at band boundaries.
- Drains one pooled row per band as a valid/ready output stream.
- Sits between the convolution output stream and the next layer's input buffer.

Parameters:
IMG_WIDTH, 8, pixels per input row; must be a multiple of POOL_SIZE
IMG_HEIGHT, 8, rows per input frame; must be a multiple of POOL_SIZE
POOL_SIZE, 2, window edge and stride
NUM_CELLS, IMG_WIDTH/POOL_SIZE, derived; number of max cells driven

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins a frame when idle
in_valid  input  1  input pixel valid
in_data  input  `DATA_WIDTH  input pixel (IEEE-754 single)
in_ready  output  1  controller accepts pixel this cycle
cell_a  output  NUM_CELLS*`DATA_WIDTH  per-cell operand; cell i occupies bits [i*DW +: DW]
cell_clear  output  NUM_CELLS  per-cell clear
cell_result  input  NUM_CELLS*`DATA_WIDTH  per-cell registered result
out_valid  output  1  pooled value valid
out_data  output  `DATA_WIDTH  pooled value
out_ready  input  1  downstream accepts
busy  output  1  high from INIT through DRAIN of the last band
done  output  1  one-cycle pulse after the last output is accepted

Behaviour:
- Reset values: state IDLE, all counters 0, in_ready 0, out_valid 0, busy 0, done 0, cell_clear all 0, cell_a all 0.
- Reset asserted mid-frame aborts immediately to IDLE; partial results are discarded.

States:
- IDLE: waits for start; start asserted in any other state is ignored.
- INIT: one cycle; cell_clear all 1; then FILL.
- FILL:
  - in_ready = 1.
  - A pixel is accepted on in_valid && in_ready.
  - The accepted pixel is driven on cell_a[col/POOL_SIZE]; all other cells receive 0.
  - Cells receive 0 every cycle with no accept.
  - 0 equals the clear value and is neutral for max.
  - col increments per accept and wraps at IMG_WIDTH-1, then row increments.
  - Accept of col==IMG_WIDTH-1 with (row+1)%POOL_SIZE==0 moves to DRAIN, with drain_idx=0.
- DRAIN:
  - in_ready = 0; all cell_a = 0.
  - out_valid = 1; out_data = cell_result[drain_idx], combinational from the registered cell output.
  - The cell updated on the final FILL edge therefore holds its final value on the first DRAIN cycle.
  - On out_valid && out_ready: cell_clear[drain_idx] = 1 for that cycle, and drain_idx increments.
  - Accept of drain_idx==NUM_CELLS-1: if row==IMG_HEIGHT, go to DONE; otherwise return to FILL.
- DONE: done = 1 for one cycle; counters reset; then IDLE.

Timing and boundary rules:
- Clear has priority over a in the same cycle inside the cell; the controller never drives a nonzero a to a cell it clears.
- Latency from the last pixel of a band to the first out_valid: 1 cycle.
- Throughput: 1 pixel per cycle in FILL; 1 output per cycle in DRAIN with out_ready held high.
- out_ready low in DRAIN: out_data and drain_idx hold; in_ready stays 0.
- Frame output count = NUM_CELLS * IMG_HEIGHT / POOL_SIZE.

Optional Feature:
POOL_OUT_REG_EN
- Defined: a one-entry output register sits after the drain mux.
  - out_valid and out_data are registered.
  - First out_valid arrives 2 cycles after the last band pixel.
  - A cell is cleared when its value is loaded into the register, not when it is accepted downstream.
  - The register loads when empty or when out_ready is high, sustaining 1 output per cycle.
  - DONE is entered only after the register empties.
- Undefined: combinational output path as described in Behaviour.

Test Plan:
- 4x4 frame, POOL_SIZE=2, rows {1,2,3,4},{4,3,2,1},{0,5,0,0},{0,0,6,0} (floats 3F800000 etc.), in_valid and out_ready held high -> outputs in order 4.0, 4.0, 5.0, 6.0; done pulses once; 16 input accepts.
- Same frame with out_ready low for 3 cycles on the first DRAIN cycle -> out_data holds 40800000; in_ready stays 0; order is unchanged.
- in_valid toggled every other cycle during FILL -> identical outputs; idle cells see cell_a=0 each cycle.
- All-negative frame (every pixel BF800000) -> every output is 00000000, because the clear value floors the max.
- rst_n pulsed low mid-band (after 5 pixels), then a new start with the first frame -> outputs match the first scenario, with no residue from the aborted frame.
- start pulsed during DRAIN -> ignored; only one done per frame.
